// File: rtl/hit_judge_pkg.sv
// Shared types and default sizing for the note-hit judge, note scroller and game controller.
package hit_judge_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int LANES_DEF    = 5;
    localparam int WINDOW_DEF   = 8;
    localparam int STREAK_W_DEF = 8;

endpackage

// File: rtl/hit_judge_if.sv
// Note handshake between the note-chart scroller (master) and the hit judge (slave).
interface hit_judge_if
    import hit_judge_pkg::*;
#(
    parameter int LANES = LANES_DEF
) ();
    logic             note_valid;
    logic [LANES-1:0] note_lanes;
    logic             note_ready;

    modport master (output note_valid, output note_lanes, input  note_ready);
    modport slave  (input  note_valid, input  note_lanes, output note_ready);
endinterface

// File: rtl/hit_judge_edge_detect.sv
// Rising-edge detector: compares each bit against its previous-cycle registered copy.
module edge_detect
    import hit_judge_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        prev_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;
endmodule

// File: rtl/hit_judge.sv
// Judges fret/strum input against one latched note chord within a tick-based window.
// HIT_JUDGE_STRUM_EN: judge on strum rising edge; otherwise on any fret rising edge.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int WINDOW   = WINDOW_DEF,
    parameter int STREAK_W = STREAK_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pause,
    input  logic                beg,
    input  logic                tick,
    input  logic [LANES-1:0]    fret,
    input  logic                strum,
    hit_judge_if.slave          note_if,
    output logic                comp,
    output logic                miss,
    output logic [STREAK_W-1:0] streak
);
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LANES-1:0]    lanes_q, lanes_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                comp_q, comp_d;
    logic                miss_q, miss_d;

    logic [LANES-1:0]    fret_rise;
    logic                strum_rise;
    logic                trigger;
    logic                ready;

    edge_detect #(.W(LANES)) u_fret_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (fret),
        .rise (fret_rise)
    );

    edge_detect #(.W(1)) u_strum_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (strum),
        .rise (strum_rise)
    );

`ifdef HIT_JUDGE_STRUM_EN
    logic unused_fret_rise;
    assign trigger          = strum_rise;
    assign unused_fret_rise = |fret_rise;
`else
    logic unused_strum_rise;
    assign trigger           = |fret_rise;
    assign unused_strum_rise = strum_rise;
`endif

    assign ready            = (state_q == IDLE) && beg && !pause;
    assign note_if.note_ready = ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lanes_d  = lanes_q;
        streak_d = streak_q;
        comp_d   = 1'b0;
        miss_d   = 1'b0;

        if (!beg) begin
            state_d  = IDLE;
            cnt_d    = '0;
            streak_d = '0;
        end else if (!pause) begin
            case (state_q)
                IDLE: begin
                    if (note_if.note_valid) begin
                        lanes_d = note_if.note_lanes;
                        cnt_d   = CNT_LOAD;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    // A trigger on the expiry tick is still judged on its chord.
                    if (trigger) begin
                        state_d = IDLE;
                        if (fret == lanes_q) begin
                            comp_d   = 1'b1;
                            streak_d = (streak_q == {STREAK_W{1'b1}}) ? streak_q
                                                                      : streak_q + 1'b1;
                        end else begin
                            miss_d   = 1'b1;
                            streak_d = '0;
                        end
                    end else if (tick) begin
                        if (cnt_q == '0) begin
                            miss_d   = 1'b1;
                            streak_d = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lanes_q  <= '0;
            streak_q <= '0;
            comp_q   <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lanes_q  <= lanes_d;
            streak_q <= streak_d;
            comp_q   <= comp_d;
            miss_q   <= miss_d;
        end
    end

    assign comp   = comp_q;
    assign miss   = miss_q;
    assign streak = streak_q;
endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios plus randomized notes against a window/streak model.
module tb_hit_judge;
    localparam int LANES  = 5;
    localparam int WINDOW = 8;
    localparam int SMAX   = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pause = 1'b0;
    logic             beg = 1'b0;
    logic             tick = 1'b0;
    logic             strum = 1'b0;
    logic [LANES-1:0] fret = '0;
    logic             comp;
    logic             miss;
    logic [7:0]       streak;

    int cmp_count  = 0;
    int fail_count = 0;
    int exp_streak = 0;

    hit_judge_if #(.LANES(LANES)) nif ();

    hit_judge #(.LANES(LANES), .WINDOW(WINDOW), .STREAK_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pause  (pause),
        .beg    (beg),
        .tick   (tick),
        .fret   (fret),
        .strum  (strum),
        .note_if(nif.slave),
        .comp   (comp),
        .miss   (miss),
        .streak (streak)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic send_note(input logic [LANES-1:0] ch, output bit ok);
        ok = 1'b0;
        nif.note_valid = 1'b1;
        nif.note_lanes = ch;
        for (int i = 0; i < 20; i++) begin
            if (nif.note_ready) begin
                cyc();
                ok = 1'b1;
                break;
            end
            cyc();
        end
        nif.note_valid = 1'b0;
    endtask

    // Press a chord as a single judged gesture; samples outputs on the cycle after the trigger.
    task automatic press(input logic [LANES-1:0] f, input bit with_tick,
                         output logic c, output logic m, output logic [7:0] s);
`ifdef HIT_JUDGE_STRUM_EN
        fret = f;
        cyc();
        strum = 1'b1;
`else
        fret = f;
`endif
        tick = with_tick;
        cyc();
        c = comp;
        m = miss;
        s = streak;
        tick  = 1'b0;
        strum = 1'b0;
        fret  = '0;
    endtask

    task automatic test_reset();
        bit ok;
        logic c, m;
        logic [7:0] s;
        cmp_count++;
        if ({comp, miss, streak, nif.note_ready} !== 11'b0) begin
            fail_count++;
            $display("FAIL reset_init got comp=%b miss=%b streak=%0d ready=%b exp all 0",
                     comp, miss, streak, nif.note_ready);
        end
        rst_n = 1'b1;
        cyc();
        beg = 1'b1;
        #1;
        send_note(5'b00011, ok);
        press(5'b00011, 1'b0, c, m, s);
        exp_streak = 1;
        cmp_count++;
        if (c !== 1'b1 || s !== 8'd1) begin
            fail_count++;
            $display("FAIL reset_pre_hit got comp=%b streak=%0d exp comp=1 streak=1", c, s);
        end
        // Assert reset while the comp pulse is live: outputs must clear immediately.
        rst_n = 1'b0;
        #1;
        cmp_count++;
        if ({comp, miss, streak} !== 10'b0) begin
            fail_count++;
            $display("FAIL reset_async got comp=%b miss=%b streak=%0d exp 0/0/0", comp, miss, streak);
        end
        cyc();
        rst_n = 1'b1;
        exp_streak = 0;
        send_note(5'b10000, ok);
        do_tick();
        do_tick();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cmp_count++;
        if (nif.note_ready !== 1'b1 || {comp, miss} !== 2'b00) begin
            fail_count++;
            $display("FAIL reset_armed got ready=%b comp=%b miss=%b exp ready=1 no pulse",
                     nif.note_ready, comp, miss);
        end
        m = 1'b0;
        for (int i = 0; i < WINDOW + 2; i++) begin
            do_tick();
            m |= miss | comp;
        end
        cmp_count++;
        if (m !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_no_expiry got pulse=%b exp 0", m);
        end
        $display("reset: done");
    endtask

    task automatic test_hit();
        bit ok;
        logic c, m;
        logic [7:0] s;
        send_note(5'b00101, ok);
        cmp_count++;
        if (ok !== 1'b1) begin
            fail_count++;
            $display("FAIL hit_transfer got ok=%b exp 1", ok);
        end
        for (int i = 0; i < 3; i++) do_tick();
        press(5'b00101, 1'b0, c, m, s);
        exp_streak = 1;
        cmp_count++;
        if (c !== 1'b1 || m !== 1'b0 || s !== 8'(exp_streak)) begin
            fail_count++;
            $display("FAIL hit_comp got comp=%b miss=%b streak=%0d exp 1/0/%0d", c, m, s, exp_streak);
        end
        cmp_count++;
        if (nif.note_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL hit_ready_next got %b exp 1", nif.note_ready);
        end
        cyc();
        cmp_count++;
        if (comp !== 1'b0) begin
            fail_count++;
            $display("FAIL hit_one_cycle got comp=%b exp 0", comp);
        end
        $display("hit: chord=00101 comp=%b streak=%0d", c, s);
    endtask

    task automatic test_wrong();
        bit ok;
        logic c, m;
        logic [7:0] s;
        for (int i = 0; i < 2; i++) begin
            send_note(5'b00101, ok);
            press(5'b00101, 1'b0, c, m, s);
            cyc();
        end
        exp_streak = 3;
        cmp_count++;
        if (streak !== 8'd3) begin
            fail_count++;
            $display("FAIL wrong_prestreak got %0d exp 3", streak);
        end
        send_note(5'b00101, ok);
        press(5'b00100, 1'b0, c, m, s);
        exp_streak = 0;
        cmp_count++;
        if (m !== 1'b1 || c !== 1'b0 || s !== 8'd0) begin
            fail_count++;
            $display("FAIL wrong_miss got comp=%b miss=%b streak=%0d exp 0/1/0", c, m, s);
        end
        cyc();
        $display("wrong: chord=00101 fret=00100 miss=%b streak=%0d", m, s);
    endtask

    task automatic test_expire();
        bit ok;
        logic c, m;
        logic [7:0] s;
        send_note(5'b11000, ok);
        m = 1'b0;
        for (int i = 0; i < WINDOW - 1; i++) begin
            do_tick();
            m |= miss | comp;
        end
        cmp_count++;
        if (m !== 1'b0) begin
            fail_count++;
            $display("FAIL expire_early got pulse=%b exp 0", m);
        end
        do_tick();
        cmp_count++;
        if (miss !== 1'b1 || comp !== 1'b0) begin
            fail_count++;
            $display("FAIL expire_miss got miss=%b comp=%b exp 1/0", miss, comp);
        end
        cyc();
        // Trigger in IDLE is ignored.
        press(5'b11000, 1'b0, c, m, s);
        cmp_count++;
        if (c !== 1'b0 || m !== 1'b0) begin
            fail_count++;
            $display("FAIL idle_ignore got comp=%b miss=%b exp 0/0", c, m);
        end
        // Trigger on the expiry tick with the right chord.
        send_note(5'b01010, ok);
        for (int i = 0; i < WINDOW - 1; i++) do_tick();
        press(5'b01010, 1'b1, c, m, s);
        exp_streak = 1;
        cmp_count++;
        if (c !== 1'b1 || m !== 1'b0 || s !== 8'd1) begin
            fail_count++;
            $display("FAIL expire_tie got comp=%b miss=%b streak=%0d exp 1/0/1", c, m, s);
        end
        cyc();
        $display("expire: miss on tick %0d, tie comp=%b", WINDOW, c);
    endtask

    task automatic test_pause();
        bit ok;
        logic p;
        send_note(5'b00110, ok);
        for (int i = 0; i < 3; i++) do_tick();
        pause = 1'b1;
        p = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_tick();
            p |= comp | miss;
        end
        fret = 5'b00110;
        strum = 1'b1;
        cyc();
        cyc();
        p |= comp | miss;
        cmp_count++;
        if (p !== 1'b0 || nif.note_ready !== 1'b0) begin
            fail_count++;
            $display("FAIL pause_frozen got pulse=%b ready=%b exp 0/0", p, nif.note_ready);
        end
        // Held buttons across unpause must not count as a fresh edge.
        pause = 1'b0;
        cyc();
        cyc();
        cmp_count++;
        if (comp !== 1'b0 || miss !== 1'b0) begin
            fail_count++;
            $display("FAIL pause_held got comp=%b miss=%b exp 0/0", comp, miss);
        end
        strum = 1'b0;
        fret  = '0;
        cyc();
        p = 1'b0;
        for (int i = 0; i < WINDOW - 4; i++) begin
            do_tick();
            p |= comp | miss;
        end
        do_tick();
        exp_streak = 0;
        cmp_count++;
        if (p !== 1'b0 || miss !== 1'b1 || streak !== 8'd0) begin
            fail_count++;
            $display("FAIL pause_resume got early=%b miss=%b streak=%0d exp 0/1/0", p, miss, streak);
        end
        cyc();
        $display("pause: window resumed, expiry after %0d more ticks", WINDOW - 3);
    endtask

    task automatic test_saturate();
        bit ok;
        logic c, m;
        logic [7:0] s;
        int bad = 0;
        for (int i = 0; i < 260; i++) begin
            send_note(5'b11111, ok);
            press(5'b11111, 1'b0, c, m, s);
            exp_streak = (exp_streak + 1 > SMAX) ? SMAX : exp_streak + 1;
            if (c !== 1'b1 || s !== 8'(exp_streak)) bad++;
        end
        cmp_count++;
        if (bad != 0 || streak !== 8'd255) begin
            fail_count++;
            $display("FAIL saturate got streak=%0d bad=%0d exp 255/0", streak, bad);
        end
        beg = 1'b0;
        cyc();
        exp_streak = 0;
        cmp_count++;
        if (streak !== 8'd0 || nif.note_ready !== 1'b0 || comp !== 1'b0 || miss !== 1'b0) begin
            fail_count++;
            $display("FAIL beg_low got streak=%0d ready=%b comp=%b miss=%b exp 0/0/0/0",
                     streak, nif.note_ready, comp, miss);
        end
        beg = 1'b1;
        cyc();
        $display("saturate: streak held 255, beg low cleared it");
    endtask

    task automatic test_random();
        bit ok;
        logic c, m;
        logic [7:0] s;
        logic [LANES-1:0] ch, f;
        int k;
        bit good, wt, exp_c, exp_m, early;
        for (int n = 0; n < 60; n++) begin
            ch = LANES'($urandom_range(1, 31));
            k  = $urandom_range(0, WINDOW + 1);
            good = $urandom_range(0, 1);
            wt   = $urandom_range(0, 1);
            f = ch;
            if (!good) begin
                do f = LANES'($urandom_range(1, 31)); while (f == ch);
            end
            send_note(ch, ok);
            early = 1'b0;
            if (k >= WINDOW) begin
                for (int i = 0; i < WINDOW; i++) begin
                    if ($urandom_range(0, 1) == 1) cyc();
                    if (i > 0) early |= comp | miss;
                    do_tick();
                end
                exp_c = 1'b0;
                exp_m = 1'b1;
                exp_streak = 0;
                c = comp;
                m = miss;
                s = streak;
                cyc();
            end else begin
                for (int i = 0; i < k; i++) begin
                    do_tick();
                    early |= comp | miss;
                end
                press(f, wt, c, m, s);
                exp_c = good;
                exp_m = !good;
                exp_streak = good ? ((exp_streak + 1 > SMAX) ? SMAX : exp_streak + 1) : 0;
                cyc();
            end
            cmp_count++;
            if (ok !== 1'b1 || early !== 1'b0 || c !== exp_c || m !== exp_m || s !== 8'(exp_streak)) begin
                fail_count++;
                $display("FAIL rand_note%0d got ok=%b early=%b comp=%b miss=%b streak=%0d exp 1/0/%b/%b/%0d",
                         n, ok, early, c, m, s, exp_c, exp_m, exp_streak);
            end
            $display("rand %0d: chord=%b fret=%b ticks=%0d comp=%b miss=%b streak=%0d",
                     n, ch, f, k, c, m, s);
        end
    endtask

    initial begin
        nif.note_valid = 1'b0;
        nif.note_lanes = '0;
        #1;
        test_reset();
        test_hit();
        test_wrong();
        test_expire();
        test_pause();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule

// File: doc/hit_judge.md
# hit_judge

Note-hit judge for the guitar-hero game datapath: accepts one note (lane chord) at a time from the note-chart scroller, opens a timing window, and judges the player's fret/strum input against it. It emits one-cycle `comp` (correct hit) or `miss` pulses that drive the game controller's scoring FSM, and tracks the current hit streak. It sits between the debounced button front end / note scroller and the controller.

## Interface
- `LANES`, 5: number of fret lanes (chord width)
- `WINDOW`, 8: hit window length in `tick` periods (≥1)
- `STREAK_W`, 8: streak counter width

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `pause`  in  1  freeze judging, window and streak
- `beg`  in  1  game running; low forces IDLE
- `tick`  in  1  one-cycle timebase pulse (window decrement)
- `fret`  in  LANES  fret buttons, debounced and synchronous to `clk`
- `strum`  in  1  strum bar, debounced and synchronous
- `note_valid`  in  1  note chord present at hit line
- `note_lanes`  in  LANES  chord to hit (nonzero)
- `note_ready`  out  1  judge accepts note this cycle (combinational)
- `comp`  out  1  one-cycle pulse: correct hit
- `miss`  out  1  one-cycle pulse: wrong input or window expired
- `streak`  out  STREAK_W  consecutive hits, saturating

## Operation
- FSM states: IDLE, ARMED.
- `note_ready` = (state==IDLE) & `beg` & ~`pause`; transfer when `note_valid` & `note_ready`: latch `note_lanes`, window counter ← WINDOW-1, go ARMED. Producer holds note until transfer.
- Trigger event: rising edge of `strum` (macro on) or rising edge of any `fret` bit (macro off); edges from `fret`/`strum` vs. previous-cycle registered copies.
- ARMED, trigger with `fret` == latched chord exactly: `comp` pulse, streak +1 (saturates at all-ones), go IDLE.
- ARMED, trigger with any other `fret` value: `miss` pulse, streak ← 0, go IDLE.
- ARMED, `tick` with counter==0 and no trigger: `miss`, streak ← 0, IDLE; `tick` with counter>0: decrement.
- Same cycle trigger and expiry: trigger judgment wins.
- Triggers in IDLE are ignored (no penalty).
- `pause` high: state, counter, streak frozen; triggers and ticks discarded; edge-history registers keep tracking so a button held across unpause is not a new edge.
- `beg` low: synchronously return to IDLE, clear counter, no pulse, streak ← 0.

## Timing
- Reset (async, `rst_n` low): IDLE, `comp`=0, `miss`=0, `streak`=0, counter=0, edge history=0; `note_ready`=0 until `beg`.
- `comp`/`miss`/`streak` registered: trigger seen in cycle N → pulse and updated streak in N+1.
- Earliest next note transfer: cycle N+1 (IDLE entered at N+1 edge).
- `comp` and `miss` never high together; each exactly one cycle.
- Reset mid-window: immediate IDLE, no pulse.

## Configuration
- `HIT_JUDGE_STRUM_EN` defined: only a `strum` rising edge triggers judgment; fret changes alone do nothing.
- Undefined: any `fret` rising edge triggers judgment; `strum` ignored.

## Structure
- `hit_judge_pkg`: state enum (IDLE, ARMED), default LANES/WINDOW constants shared with note scroller and controller.
- Sub-module `edge_detect` (parameterised width, async active-low reset, `clk`/`rst_n`), instantiated for `fret` and `strum`.

## Test plan
- Reset mid-ARMED (`rst_n` low 1 cycle) → all outputs 0, `note_ready`=1 after release with `beg`=1.
- Note 5'b00101 accepted, strum with fret=5'b00101 at tick 3 → `comp` one cycle, `streak` 0→1.
- Note 5'b00101, strum with fret=5'b00100 → `miss`, `streak` 3→0.
- No input, 8 ticks after transfer (WINDOW=8) → `miss` on cycle after 8th tick; trigger on that same tick with correct chord → `comp`, no `miss`.
- `pause` high across 20 ticks while ARMED, strum during pause → no pulse, window resumes with same count.
- 256 consecutive hits, STREAK_W=8 → `streak` holds 255; `beg` low → IDLE, `streak`=0.
